// File: rtl/router_pkg.sv
// Shared router package: default sizing and a constant-width helper.
// Used by the sync block, the router FIFO and the router FSM.
package router_pkg;

    localparam int unsigned ROUTER_TIMEOUT_DEF = 30;
    localparam int unsigned ROUTER_NUM_CH_DEF  = 3;
    localparam int unsigned ROUTER_ADDR_W_DEF  = 2;

    // Bits needed to hold values 0..value-1, never less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-channel idle timer: pulses soft_reset for one cycle after TIMEOUT
// consecutive cycles of valid-but-unread data.
module router_sync_timer
    import router_pkg::*;
#(
    parameter int unsigned TIMEOUT = ROUTER_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    localparam int unsigned CNT_W = clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             soft_reset_q;
    logic             soft_reset_d;
    logic             idle;

    assign idle       = vld & ~rd;
    assign soft_reset = soft_reset_q;

    // Next count / pulse; the pulse cycle itself also clears the counter.
    always_comb begin
        cnt_d        = '0;
        soft_reset_d = 1'b0;
        if (idle && !soft_reset_q) begin
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                soft_reset_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Timer state, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q        <= '0;
            soft_reset_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            soft_reset_q <= soft_reset_d;
        end
    end

endmodule

// File: rtl/router_sync_nch.sv
// N-channel router synchroniser: latches the header address, steers the
// FSM write strobe, muxes the addressed FIFO's full flag and soft-resets
// stale FIFOs. Optional addr_err output under ROUTER_SYNC_ADDR_ERR_EN.
module router_sync_nch
    import router_pkg::*;
#(
    parameter int unsigned NUM_CH  = ROUTER_NUM_CH_DEF,
    parameter int unsigned ADDR_W  = ROUTER_ADDR_W_DEF,
    parameter int unsigned TIMEOUT = ROUTER_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              write_enb_reg,
    input  logic [NUM_CH-1:0] read_enb,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] full,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] vld_out,
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    output logic              addr_err,
`endif
    output logic [NUM_CH-1:0] soft_reset
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    // Capture the destination on the header cycle, hold otherwise.
    always_comb begin
        addr_d = addr_q;
        if (detect_add) begin
            addr_d = data_in;
        end
    end

    // Address register, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

`ifdef ROUTER_SYNC_ADDR_ERR_EN
    logic addr_err_q;
    logic addr_err_d;

    // Flag headers that address a non-existent channel until a valid one arrives.
    always_comb begin
        addr_err_d = addr_err_q;
        if (detect_add) begin
            addr_err_d = ({{(32 - ADDR_W){1'b0}}, data_in} >= NUM_CH);
        end
    end

    // Address-error register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign addr_err = addr_err_q;
`endif

    // One-hot write steering and full mux; out-of-range address stalls the FSM.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b1;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (addr_q == ADDR_W'(i)) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    assign vld_out = ~empty;

    // One independent idle timer per channel.
    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_timer
        router_sync_timer #(
            .TIMEOUT (TIMEOUT)
        ) u_timer (
            .clk        (clk),
            .reset      (reset),
            .vld        (vld_out[g]),
            .rd         (read_enb[g]),
            .soft_reset (soft_reset[g])
        );
    end

endmodule

// File: tb/tb_router_sync_nch.sv
// Directed bench for router_sync_nch (NUM_CH=3, ADDR_W=2, TIMEOUT=30).
// Also exercises addr_err when ROUTER_SYNC_ADDR_ERR_EN is defined.
module tb_router_sync_nch;

    logic       clk;
    logic       reset;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic [2:0] read_enb;
    logic [2:0] empty;
    logic [2:0] full;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    logic       addr_err;
`endif

    int checks;
    int errors;

    router_sync_nch #(
        .NUM_CH  (3),
        .ADDR_W  (2),
        .TIMEOUT (30)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .detect_add    (detect_add),
        .data_in       (data_in),
        .write_enb_reg (write_enb_reg),
        .read_enb      (read_enb),
        .empty         (empty),
        .full          (full),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .vld_out       (vld_out),
`ifdef ROUTER_SYNC_ADDR_ERR_EN
        .addr_err      (addr_err),
`endif
        .soft_reset    (soft_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset for 2 cycles with random inputs.
        reset         = 1'b0;
        detect_add    = 1'($urandom);
        data_in       = 2'($urandom);
        write_enb_reg = 1'($urandom);
        read_enb      = 3'($urandom);
        empty         = 3'($urandom);
        full          = 3'($urandom);
        tick();
        detect_add    = 1'($urandom);
        data_in       = 2'($urandom);
        empty         = 3'($urandom);
        tick();
        detect_add    = 1'b0;
        read_enb      = 3'b000;
        empty         = 3'b111;
        write_enb_reg = 1'b1;
        full          = 3'b001;
        #1;
        chk("rst_soft_reset", 32'(soft_reset), 32'h0);
        chk("rst_write_enb", 32'(write_enb), 32'h1);
        chk("rst_fifo_full_hi", 32'(fifo_full), 32'h1);
        full = 3'b110;
        #1;
        chk("rst_fifo_full_lo", 32'(fifo_full), 32'h0);
`ifdef ROUTER_SYNC_ADDR_ERR_EN
        chk("rst_addr_err", 32'(addr_err), 32'h0);
`endif

        // Steering: new address takes effect one cycle after detect_add.
        reset      = 1'b1;
        detect_add = 1'b1;
        data_in    = 2'd2;
        #1;
        chk("steer_old_addr", 32'(write_enb), 32'h1);
        tick();
        detect_add = 1'b0;
        data_in    = 2'd0;
        full       = 3'b011;
        #1;
        chk("steer_write_enb", 32'(write_enb), 32'h4);
        chk("steer_full2_lo", 32'(fifo_full), 32'h0);
        full = 3'b100;
        #1;
        chk("steer_full2_hi", 32'(fifo_full), 32'h1);
        write_enb_reg = 1'b0;
        #1;
        chk("steer_no_req", 32'(write_enb), 32'h0);

        // Invalid address 3.
        detect_add = 1'b1;
        data_in    = 2'd3;
        tick();
        detect_add    = 1'b0;
        data_in       = 2'd0;
        write_enb_reg = 1'b1;
        full          = 3'b000;
        #1;
        chk("inv_write_enb", 32'(write_enb), 32'h0);
        chk("inv_fifo_full", 32'(fifo_full), 32'h1);
`ifdef ROUTER_SYNC_ADDR_ERR_EN
        chk("inv_addr_err", 32'(addr_err), 32'h1);
`endif
        tick();
`ifdef ROUTER_SYNC_ADDR_ERR_EN
        chk("inv_addr_err_hold", 32'(addr_err), 32'h1);
`endif
        detect_add = 1'b1;
        data_in    = 2'd1;
        tick();
        detect_add = 1'b0;
        full       = 3'b010;
        #1;
        chk("valid_write_enb", 32'(write_enb), 32'h2);
        chk("valid_fifo_full", 32'(fifo_full), 32'h1);
`ifdef ROUTER_SYNC_ADDR_ERR_EN
        chk("valid_addr_err", 32'(addr_err), 32'h0);
`endif
        write_enb_reg = 1'b0;

        // Timeout on channel 1.
        empty = 3'b101;
        #1;
        chk("vld_out", 32'(vld_out), 32'h2);
        for (int i = 1; i < 30; i++) begin
            tick();
            chk("to_wait", 32'(soft_reset), 32'h0);
        end
        tick();
        chk("to_pulse", 32'(soft_reset), 32'h2);
        tick();
        chk("to_pulse_end", 32'(soft_reset), 32'h0);
        empty = 3'b111;
        tick();

        // Read rescue on channel 0: read in idle cycle 29.
        empty = 3'b110;
        for (int i = 1; i < 29; i++) begin
            tick();
            chk("rescue_pre", 32'(soft_reset), 32'h0);
        end
        read_enb = 3'b001;
        tick();
        chk("rescue_read", 32'(soft_reset), 32'h0);
        read_enb = 3'b000;
        for (int i = 1; i < 30; i++) begin
            tick();
            chk("rescue_post", 32'(soft_reset), 32'h0);
        end
        tick();
        chk("rescue_pulse", 32'(soft_reset), 32'h1);
        tick();
        chk("rescue_pulse_end", 32'(soft_reset), 32'h0);
        empty = 3'b111;
        tick();

        // Reset during count at idle cycle 20; also reloads addr_q=0.
        empty = 3'b110;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        reset = 1'b0;
        tick();
        chk("midrst_soft_reset", 32'(soft_reset), 32'h0);
        reset         = 1'b1;
        write_enb_reg = 1'b1;
        #1;
        chk("midrst_addr0", 32'(write_enb), 32'h1);
        write_enb_reg = 1'b0;
        for (int i = 1; i < 30; i++) begin
            tick();
            chk("midrst_wait", 32'(soft_reset), 32'h0);
        end
        tick();
        chk("midrst_pulse", 32'(soft_reset), 32'h1);
        empty = 3'b111;
        tick();
        chk("midrst_pulse_end", 32'(soft_reset), 32'h0);

        // All channels time out together.
        empty = 3'b000;
        for (int i = 1; i < 30; i++) begin
            tick();
        end
        chk("all_pre", 32'(soft_reset), 32'h0);
        tick();
        chk("all_pulse", 32'(soft_reset), 32'h7);
        tick();
        chk("all_pulse_end", 32'(soft_reset), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
